// File: rtl/alu_avmm_master.sv
// alu_avmm_master: Avalon-MM master that runs one ALU job at a time.
// A job is three writes (operand A, operand B, operator), a fixed settle
// time, one read of the result, then a valid/ready response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a job
// ST_WR_A  | writing operand A
// ST_WR_B  | writing operand B
// ST_WR_OP | writing operator, which triggers the slave
// ST_WAIT  | settle time, WAIT_CYCLES cycles, no strobes
// ST_RD    | reading result register, captured on the closing edge
// ST_RSP   | rsp_valid high, result held until rsp_ready
module alu_avmm_master #(
    parameter logic [2:0] ADDR_OPA    = 3'd0,
    parameter logic [2:0] ADDR_OPB    = 3'd1,
    parameter logic [2:0] ADDR_OPR    = 3'd2,
    parameter logic [2:0] ADDR_RES    = 3'd3,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_opa,
    input  logic [15:0] cmd_opb,
    input  logic [3:0]  cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_op,
    output logic [2:0]  avm_address,
    output logic [31:0] avm_write_data,
    output logic        avm_write,
    output logic        avm_read,
    input  logic [31:0] avm_read_data,
    output logic        busy,
    output logic [15:0] jobs_done
);

    // The slave latches its trigger on the operator write and updates the
    // result one edge later, so at least one idle cycle is mandatory.
    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("alu_avmm_master: WAIT_CYCLES must be at least 1");
        end
    endgenerate

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_WR_OP,
        ST_WAIT,
        ST_RD,
        ST_RSP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [15:0]      opb_q;
    logic [3:0]       op_q;

    // Sequencer: bus strobes are set up one edge ahead so they are registered
    // and valid for the whole cycle of the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            opb_q          <= '0;
            op_q           <= '0;
            avm_address    <= '0;
            avm_write_data <= '0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_result     <= '0;
            rsp_op         <= '0;
            jobs_done      <= '0;
        end else begin
            avm_address    <= '0;
            avm_write_data <= '0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        opb_q          <= cmd_opb;
                        op_q           <= cmd_op;
                        avm_write      <= 1'b1;
                        avm_address    <= ADDR_OPA;
                        avm_write_data <= {16'd0, cmd_opa};
                        state          <= ST_WR_A;
                    end
                end
                ST_WR_A: begin
                    avm_write      <= 1'b1;
                    avm_address    <= ADDR_OPB;
                    avm_write_data <= {16'd0, opb_q};
                    state          <= ST_WR_B;
                end
                ST_WR_B: begin
                    avm_write      <= 1'b1;
                    avm_address    <= ADDR_OPR;
                    avm_write_data <= {28'd0, op_q};
                    state          <= ST_WR_OP;
                end
                ST_WR_OP: begin
                    wait_cnt <= CNT_LOAD;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_RES;
                        state       <= ST_RD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RD: begin
                    rsp_result <= avm_read_data;
                    rsp_op     <= op_q;
                    rsp_valid  <= 1'b1;
                    state      <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        jobs_done <= jobs_done + 16'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_avmm_master.sv
// Testbench for alu_avmm_master: bus-level ALU slave model, a timeline
// model of the expected outputs checked every cycle, and directed jobs
// with hand-computed results.
module tb_alu_avmm_master;

    localparam int W = 2;
    localparam logic [2:0] A_OPA = 3'd0;
    localparam logic [2:0] A_OPB = 3'd1;
    localparam logic [2:0] A_OPR = 3'd2;
    localparam logic [2:0] A_RES = 3'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_opa, cmd_opb;
    logic [3:0]  cmd_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_op;
    logic [2:0]  avm_address;
    logic [31:0] avm_write_data, avm_read_data;
    logic        avm_write, avm_read, busy;
    logic [15:0] jobs_done;

    logic        c1_valid, c1_ready;
    logic [15:0] c1_opa, c1_opb;
    logic [3:0]  c1_op;
    logic        c1_rsp_valid, c1_rsp_ready;
    logic [31:0] c1_rsp_result;
    logic [3:0]  c1_rsp_op;
    logic [2:0]  c1_address;
    logic [31:0] c1_wdata, c1_rdata;
    logic        c1_write, c1_read, c1_busy;
    logic [15:0] c1_jobs;

    alu_avmm_master #(.WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op),
        .avm_address(avm_address), .avm_write_data(avm_write_data),
        .avm_write(avm_write), .avm_read(avm_read),
        .avm_read_data(avm_read_data),
        .busy(busy), .jobs_done(jobs_done)
    );

    alu_avmm_master #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_opa(c1_opa), .cmd_opb(c1_opb), .cmd_op(c1_op),
        .rsp_valid(c1_rsp_valid), .rsp_ready(c1_rsp_ready),
        .rsp_result(c1_rsp_result), .rsp_op(c1_rsp_op),
        .avm_address(c1_address), .avm_write_data(c1_wdata),
        .avm_write(c1_write), .avm_read(c1_read),
        .avm_read_data(c1_rdata),
        .busy(c1_busy), .jobs_done(c1_jobs)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ALU slave behaviour: 17-bit add/sub, 32-bit product, unknown codes give 0.
    function automatic logic [31:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0:    return {16'd0, a} + {16'd0, b};
            4'd1:    return ({16'd0, a} - {16'd0, b}) & 32'h0001_FFFF;
            4'd2:    return {16'd0, a} * {16'd0, b};
            4'd3:    return (b == 16'd0) ? 32'd0 : {16'd0, a / b};
            4'd4:    return {16'd0, a} << b[4:0];
            4'd5:    return {16'd0, a} >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Slave for the W=2 instance: trigger on operator write, result one edge later.
    logic [15:0] s0_a = '0, s0_b = '0;
    logic [3:0]  s0_op = '0;
    logic        s0_trig = 1'b0;
    logic [31:0] s0_res = '0;
    always @(posedge clk) begin
        if (s0_trig) s0_res <= alu_ref(s0_a, s0_b, s0_op);
        s0_trig <= 1'b0;
        if (avm_write) begin
            case (avm_address)
                A_OPA: s0_a <= avm_write_data[15:0];
                A_OPB: s0_b <= avm_write_data[15:0];
                A_OPR: begin s0_op <= avm_write_data[3:0]; s0_trig <= 1'b1; end
                default: ;
            endcase
        end
    end
    assign avm_read_data = s0_res;

    // Slave for the W=1 instance.
    logic [15:0] s1_a = '0, s1_b = '0;
    logic [3:0]  s1_op = '0;
    logic        s1_trig = 1'b0;
    logic [31:0] s1_res = '0;
    always @(posedge clk) begin
        if (s1_trig) s1_res <= alu_ref(s1_a, s1_b, s1_op);
        s1_trig <= 1'b0;
        if (c1_write) begin
            case (c1_address)
                A_OPA: s1_a <= c1_wdata[15:0];
                A_OPB: s1_b <= c1_wdata[15:0];
                A_OPR: begin s1_op <= c1_wdata[3:0]; s1_trig <= 1'b1; end
                default: ;
            endcase
        end
    end
    assign c1_rdata = s1_res;

    always @(posedge clk) cyc <= cyc + 1;

    // Job timeline model: a job accepted in cycle t0 writes in t0+1..t0+3,
    // idles W cycles, reads in t0+4+W and responds from t0+5+W.
    logic        m_job  = 1'b0;
    int          m_t0   = 0;
    logic [15:0] m_a    = '0, m_b = '0;
    logic [3:0]  m_op   = '0;
    logic [31:0] m_res  = '0;
    logic [3:0]  m_rop  = '0;
    logic [15:0] m_jobs = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_job  <= 1'b0;
            m_res  <= '0;
            m_rop  <= '0;
            m_jobs <= '0;
        end else if (!m_job) begin
            if (cmd_valid) begin
                m_job <= 1'b1;
                m_t0  <= cyc;
                m_a   <= cmd_opa;
                m_b   <= cmd_opb;
                m_op  <= cmd_op;
            end
        end else begin
            if (cyc - m_t0 == W + 4) begin
                m_res <= alu_ref(m_a, m_b, m_op);
                m_rop <= m_op;
            end
            if (cyc - m_t0 >= W + 5 && rsp_ready) begin
                m_job  <= 1'b0;
                m_jobs <= m_jobs + 16'd1;
            end
        end
    end

    int          e_k;
    logic        e_wr, e_rd, e_rv;
    logic [2:0]  e_addr;
    logic [31:0] e_wdata;
    always_comb begin
        e_k     = cyc - m_t0;
        e_wr    = 1'b0;
        e_rd    = 1'b0;
        e_rv    = 1'b0;
        e_addr  = '0;
        e_wdata = '0;
        if (m_job) begin
            if (e_k == 1) begin
                e_wr = 1'b1; e_addr = A_OPA; e_wdata = {16'd0, m_a};
            end else if (e_k == 2) begin
                e_wr = 1'b1; e_addr = A_OPB; e_wdata = {16'd0, m_b};
            end else if (e_k == 3) begin
                e_wr = 1'b1; e_addr = A_OPR; e_wdata = {28'd0, m_op};
            end else if (e_k == W + 4) begin
                e_rd = 1'b1; e_addr = A_RES;
            end else if (e_k >= W + 5) begin
                e_rv = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmd_ready", cmd_ready, !m_job);
            check("busy", busy, m_job);
            check("avm_write", avm_write, e_wr);
            check("avm_read", avm_read, e_rd);
            check("avm_address", avm_address, e_addr);
            check("avm_write_data", avm_write_data, e_wdata);
            check("rsp_valid", rsp_valid, e_rv);
            check("rsp_result", rsp_result, m_res);
            check("rsp_op", rsp_op, m_rop);
            check("jobs_done", jobs_done, m_jobs);
        end
    end

    int acc[$];
    always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) acc.push_back(cyc);

    logic [34:0] wr_log[$];

    // Call at a negedge with the W=2 instance idle.
    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                           input int hold, output logic [31:0] res, output logic [3:0] rop,
                           output int lat, output int rd_off, output logic [2:0] rd_addr,
                           output logic [15:0] jd_pre);
        int n;
        wr_log.delete();
        cmd_opa = a; cmd_opb = b; cmd_op = op; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = -1; rd_off = -1; rd_addr = '1; n = 0;
        while (lat < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (avm_write) wr_log.push_back({avm_address, avm_write_data});
            if (avm_read) begin rd_off = n; rd_addr = avm_address; end
            if (rsp_valid) lat = n;
        end
        if (lat < 0) check("rsp_valid_timeout", rsp_valid, 1'b1);
        res = rsp_result;
        rop = rsp_op;
        repeat (hold) @(negedge clk);
        jd_pre = jobs_done;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [31:0] res;
    logic [3:0]  rop;
    int          lat, rd_off, n;
    logic [2:0]  rd_addr;
    logic [15:0] jd_pre;
    logic [34:0] exp_tr[3];

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opa = '0; cmd_opb = '0; cmd_op = '0;
        c1_valid = 1'b0; c1_rsp_ready = 1'b0;
        c1_opa = '0; c1_opb = '0; c1_op = '0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_jobs", jobs_done, 16'd0);
        check("rst_avm_write", avm_write, 1'b0);
        check("rst_rsp_result", rsp_result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // add: bus trace and latency
        run_job(16'd3, 16'd4, 4'd0, 0, res, rop, lat, rd_off, rd_addr, jd_pre);
        exp_tr[0] = {3'd0, 32'd3};
        exp_tr[1] = {3'd1, 32'd4};
        exp_tr[2] = {3'd2, 32'd0};
        check("add_nwrites", wr_log.size(), 3);
        for (int i = 0; i < 3; i++)
            check("add_write_trace", (wr_log.size() > i) ? wr_log[i] : '1, exp_tr[i]);
        check("add_read_cycle", rd_off, 6);
        check("add_read_addr", rd_addr, 3'd3);
        check("add_rsp_cycle", lat, 7);
        check("add_result", res, 32'h0000_0007);
        check("add_op", rop, 4'd0);

        run_job(16'd5, 16'd7, 4'd1, 0, res, rop, lat, rd_off, rd_addr, jd_pre);
        check("sub_result", res, 32'h0001_FFFE);

        // mul with 5 cycles of backpressure
        run_job(16'h1234, 16'h0010, 4'd2, 5, res, rop, lat, rd_off, rd_addr, jd_pre);
        check("mul_result", res, 32'h0001_2340);
        check("mul_held_result", rsp_result, 32'h0001_2340);
        check("bp_jobs_before", jd_pre, 16'd2);
        check("bp_jobs_after", jobs_done, 16'd3);

        run_job(16'h0055, 16'h0066, 4'd7, 0, res, rop, lat, rd_off, rd_addr, jd_pre);
        check("op7_result", res, 32'd0);
        check("op7_op", rop, 4'd7);

        // reset in the first WAIT cycle
        cmd_opa = 16'd1; cmd_opb = 16'd2; cmd_op = 4'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_write", avm_write, 1'b0);
        check("midrst_read", avm_read, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_jobs", jobs_done, 16'd0);
        check("midrst_result", rsp_result, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_job(16'd9, 16'd1, 4'd5, 0, res, rop, lat, rd_off, rd_addr, jd_pre);
        check("shr_result", res, 32'h0000_0004);
        check("post_rst_jobs", jobs_done, 16'd1);

        // back-to-back jobs: IDLE, three writes, W waits, read, response
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        acc.delete();
        cmd_opa = 16'd2; cmd_opb = 16'd3; cmd_op = 4'd2;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (acc.size() < 3 && n < 100) begin @(negedge clk); n++; end
        cmd_valid = 1'b0;
        while (jobs_done != 16'd3 && n < 200) begin @(negedge clk); n++; end
        rsp_ready = 1'b0;
        check("b2b_jobs", jobs_done, 16'd3);
        check("b2b_accepts", acc.size(), 3);
        check("b2b_gap1", (acc.size() > 1) ? acc[1] - acc[0] : -1, 8);
        check("b2b_gap2", (acc.size() > 2) ? acc[2] - acc[1] : -1, 8);
        check("b2b_result", rsp_result, 32'd6);

        // W=1 instance: read one cycle earlier, counter wraps
        force u1.jobs_done = 16'hFFFF;
        @(negedge clk);
        release u1.jobs_done;
        c1_opa = 16'd3; c1_opb = 16'd4; c1_op = 4'd0; c1_valid = 1'b1;
        @(posedge clk); #1;
        c1_valid = 1'b0;
        rd_off = -1; lat = -1; n = 0;
        while (lat < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (c1_read) rd_off = n;
            if (c1_rsp_valid) lat = n;
        end
        check("w1_read_cycle", rd_off, 5);
        check("w1_rsp_cycle", lat, 6);
        check("w1_result", c1_rsp_result, 32'h0000_0007);
        check("w1_jobs_pre", c1_jobs, 16'hFFFF);
        c1_rsp_ready = 1'b1;
        @(negedge clk);
        c1_rsp_ready = 1'b0;
        check("w1_jobs_wrap", c1_jobs, 16'd0);
        check("w1_idle", c1_busy, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
